// File: rtl/uart_tx_buffer_ctrl_if.sv
// Bundle of producer, BRAM and UART-side signals around the TX buffer controller.
// master: the controller itself. slave: producers, BRAM and uart_tx around it.
interface uart_tx_buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  // producer side
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  flush;
  logic                  clr_overflow;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   count;
  // BRAM ports
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_waddr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic [ADDR_WIDTH-1:0] bram_raddr;
  logic [DATA_WIDTH-1:0] bram_rdata;
  // UART transmitter handshake
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  push, push_data, flush, clr_overflow, bram_rdata, tx_ready,
    output full, empty, overflow, count,
    output bram_we, bram_waddr, bram_wdata, bram_raddr,
    output tx_data, tx_valid
  );

  modport slave (
    output push, push_data, flush, clr_overflow, bram_rdata, tx_ready,
    input  full, empty, overflow, count,
    input  bram_we, bram_waddr, bram_wdata, bram_raddr,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_buffer_ctrl.sv
// Circular TX FIFO controller around a dual-port byte BRAM with a 1-cycle
// registered read. Producers push bytes; a three-state read sequencer
// (IDLE -> FETCH -> VALID) pulls them out and offers them to uart_tx.
module uart_tx_buffer_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  uart_tx_buffer_ctrl_if.master bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_valid_reg;
  logic                  overflow_reg;

  logic full_w;
  logic push_ok;
  logic pop;

  // full/empty derive from the occupancy counter, never from pointer compare
  assign full_w  = (count_reg == DEPTH_CNT);
  assign push_ok = bus.push & ~full_w & ~bus.flush;
  // the byte leaves the BRAM on the FETCH -> VALID edge (flush cancels it)
  assign pop     = (state_reg == FETCH) & ~bus.flush;

  assign bus.full       = full_w;
  assign bus.empty      = (count_reg == '0);
  assign bus.overflow   = overflow_reg;
  assign bus.count      = count_reg;
  assign bus.bram_we    = push_ok;
  assign bus.bram_waddr = wr_ptr_reg;
  assign bus.bram_wdata = bus.push_data;
  assign bus.bram_raddr = rd_ptr_reg;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_valid   = tx_valid_reg;

  // Pointers, occupancy and sticky overflow; flush wipes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop)
        count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop)
        count_reg <= count_reg - 1'b1;
      // a dropped push sets the flag even if clr_overflow is also asserted
      if (bus.push && full_w)
        overflow_reg <= 1'b1;
      else if (bus.clr_overflow)
        overflow_reg <= 1'b0;
    end
  end

  // Read sequencer: IDLE issues the BRAM read, FETCH captures it, VALID waits for the UART
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      state_reg    <= IDLE;
      tx_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // registered count guarantees the addressed byte was written earlier
          if (count_reg != '0)
            state_reg <= FETCH;
        end
        FETCH: begin
          tx_data_reg  <= bus.bram_rdata;
          tx_valid_reg <= 1'b1;
          state_reg    <= VALID;
        end
        VALID: begin
          if (bus.tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          tx_valid_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffer_ctrl.sv
// Bench for uart_tx_buffer_ctrl with a 4-deep FIFO and a behavioural BRAM.
// Reference: a queue of bytes held by the controller (BRAM plus the offered byte).
module tb_uart_tx_buffer_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buffer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_tx_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural dual-port BRAM: registered read, read-before-write
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    bus.bram_rdata <= mem[bus.bram_raddr];
    if (bus.bram_we) mem[bus.bram_waddr] <= bus.bram_wdata;
  end

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] q[$];
  bit   ovf_m = 1'b0;
  int   wp_m  = 0;
  int   ndeliv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs after the falling edge, check combinational
  // outputs, predict the edge, then check the registered state afterwards.
  task automatic drive(input bit p, input logic [DW-1:0] d, input bit f,
                       input bit c, input bit r, input bit acc);
    int occ;
    bus.push = p; bus.push_data = d; bus.flush = f;
    bus.clr_overflow = c; bus.tx_ready = r;
    #1;
    chk("bram_we", {31'd0, bus.bram_we}, {31'd0, acc});
    if (acc) begin
      chk("bram_waddr", 32'(bus.bram_waddr), 32'(wp_m));
      chk("bram_wdata", 32'(bus.bram_wdata), 32'(d));
    end
    if (bus.tx_valid && r && !f) begin
      if (q.size() == 0) chk("tx_unexpected", {31'd0, bus.tx_valid}, 32'd0);
      else begin
        chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        $display("tx byte %02h delivered", bus.tx_data);
        void'(q.pop_front());
        ndeliv++;
      end
    end
    if (f) begin
      q.delete(); ovf_m = 1'b0; wp_m = 0;
    end else begin
      if (acc) begin q.push_back(d); wp_m = (wp_m + 1) % DEPTH; end
      if (p && !acc) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    occ = int'(bus.count) + int'(bus.tx_valid);
    chk("occupancy", 32'(occ), 32'(q.size()));
    chk("overflow", {31'd0, bus.overflow}, {31'd0, ovf_m});
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
    chk("empty_after_drain", {31'd0, bus.empty}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int guard;
    bit p;
    bit r;
    bus.push = 0; bus.push_data = '0; bus.flush = 0;
    bus.clr_overflow = 0; bus.tx_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);

    // T1: asynchronous reset while a byte is being offered
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_before", {31'd0, bus.tx_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_empty", {31'd0, bus.empty}, 32'd1);
    chk("t1_full", {31'd0, bus.full}, 32'd0);
    chk("t1_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("t1_bram_we", {31'd0, bus.bram_we}, 32'd0);
    q.delete(); ovf_m = 1'b0; wp_m = 0;
    @(negedge clk);
    rst = 1'b0;

    // T2: single byte, valid three edges after the push, for exactly one cycle
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2_valid_e1", {31'd0, bus.tx_valid}, 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_e2", {31'd0, bus.tx_valid}, 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_e3", {31'd0, bus.tx_valid}, 32'd1);
    chk("t2_data_e3", 32'(bus.tx_data), 32'h41);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_e4", {31'd0, bus.tx_valid}, 32'd0);
    chk("t2_count", 32'(bus.count), 32'd0);

    // T3: fill to full, drop one (overflow set beats clr in the same cycle)
    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_full", {31'd0, bus.full}, 32'd1);
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_head", 32'(bus.tx_data), 32'h10);
    drive(1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_overflow", {31'd0, bus.overflow}, 32'd1);
    drain(40);
    chk("t3_overflow_sticky", {31'd0, bus.overflow}, 32'd1);

    // T6: flush while offering with tx_ready and push asserted
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid_before", {31'd0, bus.tx_valid}, 32'd1);
    idx = ndeliv;
    drive(1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_no_handshake", 32'(ndeliv), 32'(idx));
    chk("t6_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_overflow", {31'd0, bus.overflow}, 32'd0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(20);
    chk("t6_next_delivered", 32'(ndeliv), 32'(idx + 1));

    // T5: push lands on the FETCH -> VALID edge
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_count", 32'(bus.count), 32'd1);
    chk("t5_valid", {31'd0, bus.tx_valid}, 32'd1);
    chk("t5_data", 32'(bus.tx_data), 32'h5A);
    drain(20);

    // T4: wrap-around with random gaps and random tx_ready
    idx = 0;
    guard = 0;
    while (idx < 12 && guard < 2000) begin
      r = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 2) == 0) && (q.size() < DEPTH);
      drive(p, 8'(idx), 1'b0, 1'b0, r, p);
      if (p) idx++;
      guard++;
    end
    chk("t4_all_pushed", 32'(idx), 32'd12);
    drain(60);
    chk("t4_overflow", {31'd0, bus.overflow}, 32'd0);

    // clr_overflow alone clears the sticky flag
    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    drain(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
